force_ring_router: RTL
======================

FORCE_RING_ROUTER -- requirements
Module: force_ring_router

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, force component width.
REQ-002 SHALL have parameter PARTICLE_ID_WIDTH, default 7, particle id width.
REQ-003 SHALL have parameter NODE_ID_WIDTH, default 6, ring node address width.
REQ-004 SHALL have parameter HOME_CELL_ID, default 0, this node's address.
REQ-005 SHALL have parameter NUM_PE, default 2, number of local PE injection ports (1..8).
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, per-port injection FIFO depth (power of 2, >=2).
REQ-007 SHALL derive FORCE_DATA_WIDTH = 3*DATA_WIDTH+PARTICLE_ID_WIDTH and PACKET_WIDTH = FORCE_DATA_WIDTH+NODE_ID_WIDTH; packet = {dest[NODE_ID_WIDTH], payload[FORCE_DATA_WIDTH]}, dest in MSBs.
REQ-008 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-009 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-010 SHALL have port pe_pkt_in  in  NUM_PE*PACKET_WIDTH  port i in slice [i*PACKET_WIDTH +: PACKET_WIDTH].
REQ-011 SHALL have port pe_pkt_valid  in  NUM_PE  per-port valid.
REQ-012 SHALL have port pe_ready  out  NUM_PE  per-port ready.
REQ-013 SHALL have ports prev_pkt_in  in  PACKET_WIDTH, and prev_pkt_valid  in  1  ring packet from previous node.
REQ-014 SHALL have ports fc_data_out  out  FORCE_DATA_WIDTH, and fc_data_valid  out  1  payload to force cache.
REQ-015 SHALL have ports nxt_pkt_out  out  PACKET_WIDTH, and nxt_pkt_valid  out  1  packet to next node.

Function
REQ-016 SHALL accept a ring packet unconditionally (no ring backpressure); dest==HOME_CELL_ID -> fc outputs, else -> nxt outputs, registered, 1-cycle latency.
REQ-017 SHALL buffer each PE port in its own FIFO; pe_ready[i] = not full, from registered state only; push on pe_pkt_valid[i]&pe_ready[i].
REQ-018 SHALL treat a FIFO head as eligible when its target output is unclaimed this cycle: home-dest needs no matching ring packet, remote-dest needs no non-matching ring packet.
REQ-019 SHALL grant at most one eligible head per cycle, round-robin starting at rr_ptr; on grant, pop that FIFO, drive its packet to the target output next edge, set rr_ptr = grant+1 mod NUM_PE; rr_ptr unchanged when no grant.
REQ-020 SHALL allow one ring packet and one granted head in the same cycle when their targets differ.
REQ-021 SHALL NOT bypass FIFOs: a packet pushed on edge t is eligible in the cycle after t, earliest output after edge t+1.
REQ-022 SHALL allow push and pop of the same FIFO in one cycle (count unchanged); full FIFO accepts no push even if popped that cycle.
REQ-023 SHALL drive fc_data_out/nxt_pkt_out to zero whenever the corresponding valid is low.
REQ-024 SHALL preserve per-port order; no ordering guarantee across ports.

Reset
REQ-025 SHALL on rst assertion immediately clear all FIFOs, rr_ptr=0, fc_data_valid=0, nxt_pkt_valid=0, data outputs=0, pe_ready=all ones; in-flight packets discarded.
REQ-026 SHALL accept no push while rst is high.

Configuration
REQ-027 SHALL, with RING_ROUTER_STATS_EN defined, add outputs stat_inject_cnt, stat_eject_cnt, stat_stall_cnt (32 bits each): granted heads, fc_data_valid cycles, cycles with a non-empty FIFO but no grant; saturating, cleared by rst.
REQ-028 SHALL, without RING_ROUTER_STATS_EN, omit those ports and counters entirely.

Verification
REQ-029 Ring only: prev dest=0 payload=0x11 -> next cycle fc_data_valid=1, fc_data_out=0x11, nxt_pkt_valid=0.
REQ-030 Collision: PE0 head dest=5 while ring streams dest=5 for 3 cycles -> PE0 held, emitted on nxt in cycle after stream ends.
REQ-031 Fairness: PE0 and PE1 each push 4 remote packets, idle ring -> nxt order alternates P0,P1,P0,P1...; all 8 delivered.
REQ-032 Full: 4 pushes to PE0 with ring saturated by remote packets -> pe_ready[0]=0 after 4th push; rises after first pop.
REQ-033 Dual use: ring dest=0 plus PE1 head dest=3 same cycle -> fc and nxt both valid next cycle.
REQ-034 Async reset mid-traffic: assert rst between edges -> valids and FIFO counts 0 before next edge, pe_ready all ones.

Source files
------------

// File: rtl/force_ring_router.sv
// Ring node router: forwards ring packets and arbitrates buffered local PE packets onto the
// force-cache (home) or next-node (remote) output. Optional counters under RING_ROUTER_STATS_EN.
module force_ring_router #(
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int NODE_ID_WIDTH     = 6,
  parameter int HOME_CELL_ID      = 0,
  parameter int NUM_PE            = 2,
  parameter int FIFO_DEPTH        = 4,
  localparam int FORCE_DATA_WIDTH = 3*DATA_WIDTH+PARTICLE_ID_WIDTH,
  localparam int PACKET_WIDTH     = FORCE_DATA_WIDTH+NODE_ID_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PE*PACKET_WIDTH-1:0] pe_pkt_in,
  input  logic [NUM_PE-1:0]              pe_pkt_valid,
  output logic [NUM_PE-1:0]              pe_ready,
  input  logic [PACKET_WIDTH-1:0]        prev_pkt_in,
  input  logic                           prev_pkt_valid,
  output logic [FORCE_DATA_WIDTH-1:0]    fc_data_out,
  output logic                           fc_data_valid,
  output logic [PACKET_WIDTH-1:0]        nxt_pkt_out,
  output logic                           nxt_pkt_valid
`ifdef RING_ROUTER_STATS_EN
  ,
  output logic [31:0]                    stat_inject_cnt,
  output logic [31:0]                    stat_eject_cnt,
  output logic [31:0]                    stat_stall_cnt
`endif
);

  localparam int FDW   = FORCE_DATA_WIDTH;
  localparam int PW    = PACKET_WIDTH;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic [PW-1:0]    mem [NUM_PE][FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr [NUM_PE];
  logic [AW-1:0]    wr_ptr [NUM_PE];
  logic [AW:0]      count [NUM_PE];
  logic [PTR_W-1:0] rr_ptr;

  logic [NUM_PE-1:0] push, pop, nonempty, elig, head_home;
  logic [PW-1:0]     head [NUM_PE];
  logic              ring_home, ring_remote;
  logic              grant_valid, grant_home;
  logic [PTR_W-1:0]  grant_idx, rr_next;
  logic [PW-1:0]     grant_pkt;

  assign ring_home   = prev_pkt_valid &&
                       (prev_pkt_in[PW-1 -: NODE_ID_WIDTH] == NODE_ID_WIDTH'(HOME_CELL_ID));
  assign ring_remote = prev_pkt_valid && !ring_home;

  // Ready depends only on registered occupancy, so a popping full FIFO still refuses a push.
  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      pe_ready[i]  = (count[i] != (AW+1)'(FIFO_DEPTH));
      push[i]      = pe_pkt_valid[i] && pe_ready[i] && !rst;
      nonempty[i]  = (count[i] != '0);
      head[i]      = mem[i][rd_ptr[i]];
      head_home[i] = (head[i][PW-1 -: NODE_ID_WIDTH] == NODE_ID_WIDTH'(HOME_CELL_ID));
      elig[i]      = nonempty[i] && (head_home[i] ? !ring_home : !ring_remote);
    end
  end

  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_PE;
      if (!grant_valid && elig[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
    rr_next    = (grant_idx == PTR_W'(NUM_PE-1)) ? '0 : grant_idx + 1'b1;
    grant_pkt  = head[grant_idx];
    grant_home = head_home[grant_idx];
    for (int i = 0; i < NUM_PE; i++)
      pop[i] = grant_valid && (grant_idx == PTR_W'(i));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PE; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= pe_pkt_in[i*PW +: PW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PE; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PE; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Ring traffic always wins its output; a granted head only ever takes the other one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr        <= '0;
      fc_data_valid <= 1'b0;
      fc_data_out   <= '0;
      nxt_pkt_valid <= 1'b0;
      nxt_pkt_out   <= '0;
    end else begin
      if (grant_valid) rr_ptr <= rr_next;
      fc_data_valid <= ring_home || (grant_valid && grant_home);
      nxt_pkt_valid <= ring_remote || (grant_valid && !grant_home);
      if (ring_home)                       fc_data_out <= prev_pkt_in[FDW-1:0];
      else if (grant_valid && grant_home)  fc_data_out <= grant_pkt[FDW-1:0];
      else                                 fc_data_out <= '0;
      if (ring_remote)                     nxt_pkt_out <= prev_pkt_in;
      else if (grant_valid && !grant_home) nxt_pkt_out <= grant_pkt;
      else                                 nxt_pkt_out <= '0;
    end
  end

`ifdef RING_ROUTER_STATS_EN
  logic stall;
  assign stall = (|nonempty) && !grant_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_inject_cnt <= '0;
      stat_eject_cnt  <= '0;
      stat_stall_cnt  <= '0;
    end else begin
      if (grant_valid && stat_inject_cnt != '1)  stat_inject_cnt <= stat_inject_cnt + 1'b1;
      if (fc_data_valid && stat_eject_cnt != '1) stat_eject_cnt  <= stat_eject_cnt + 1'b1;
      if (stall && stat_stall_cnt != '1)         stat_stall_cnt  <= stat_stall_cnt + 1'b1;
    end
  end
`endif

endmodule
